// File: rtl/fetch_unit_pkg.sv
// Shared constants, aligner case encoding and the compressed-instruction
// check used by the instruction fetch front end.
package fetch_unit_pkg;

    // PC increments for a 16-bit and a 32-bit instruction
    localparam int unsigned ILEN_C = 32'd2;
    localparam int unsigned ILEN_W = 32'd4;

    // Which half of the head word the aligner is looking at, and what it found there
    typedef enum logic [1:0] {
        ALN_C_LO = 2'd0,  // compressed instruction in head[15:0]
        ALN_W_LO = 2'd1,  // 32-bit instruction equal to the head word
        ALN_C_HI = 2'd2,  // compressed instruction in head[31:16]
        ALN_W_HI = 2'd3   // 32-bit instruction split across head and next word
    } aln_case_e;

    // A parcel is compressed unless its two lowest bits are both set
    function automatic logic is_c(input logic [15:0] h);
        return (h[1:0] != 2'b11);
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Handshake bundle between the fetch unit, instruction memory, the
// redirect source and the decode stage.
interface fetch_unit_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          redirect_valid;
    logic [AW-1:0] redirect_pc;
    logic          imem_req_valid;
    logic          imem_req_ready;
    logic [AW-1:0] imem_req_addr;
    logic          imem_rsp_valid;
    logic [DW-1:0] imem_rsp_data;
    logic          instr_valid;
    logic          instr_ready;
    logic [DW-1:0] instr;
    logic [AW-1:0] instr_pc;
    logic          instr_is_c;

    // Fetch unit side
    modport master (
        input  redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid,
               imem_rsp_data, instr_ready,
        output imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc,
               instr_is_c
    );

    // Memory / decode / redirect side
    modport slave (
        output redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid,
               imem_rsp_data, instr_ready,
        input  imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc,
               instr_is_c
    );
endinterface

// File: rtl/fetch_unit_fifo.sv
// Prefetch word FIFO: synchronous write/read, flush, exposes the head word,
// the word behind it and the occupancy.
module fetch_fifo #(
    parameter  int DW    = 32,
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] head,
    output logic [DW-1:0] next,
    output logic [CW-1:0] count
);
    logic [DW-1:0] mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic [PW-1:0] next_idx_s;

    // Pointer and occupancy tracking; pointers wrap naturally at DEPTH
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push) wr_ptr_r <= wr_ptr_r + {{(PW-1){1'b0}}, 1'b1};
            if (pop)  rd_ptr_r <= rd_ptr_r + {{(PW-1){1'b0}}, 1'b1};
            count_r <= count_r + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};
        end
    end

    // Word storage; a flushed push is simply not written
    always_ff @(posedge clk) begin
        if (push && !flush) mem_r[wr_ptr_r] <= push_data;
    end

    assign next_idx_s = rd_ptr_r + {{(PW-1){1'b0}}, 1'b1};
    assign head  = mem_r[rd_ptr_r];
    assign next  = mem_r[next_idx_s];
    assign count = count_r;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: credit-based word requests, response
// dropping after redirects, and 16/32-bit instruction alignment.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int            AW     = 32,
    parameter int            DW     = 32,
    parameter int            DEPTH  = 4,
    parameter logic [AW-1:0] RST_PC = 32'h0000_0000
) (
    input logic          clk,
    input logic          rst,
    fetch_unit_if.master bus
);
    localparam int            CW      = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [AW-1:0] fetch_addr_r;
    logic [CW-1:0] out_cnt_r;
    logic [CW-1:0] drop_cnt_r;
    logic          off_r;
    logic [AW-1:0] cur_pc_r;

    logic [DW-1:0] head_s;
    logic [DW-1:0] next_s;
    logic [CW-1:0] count_s;
    logic [CW-1:0] credit_s;
    logic          req_valid_s;
    logic          req_fire_s;
    logic          rsp_keep_s;
    logic          consume_s;
    logic          pop_s;
    logic [CW-1:0] out_next_s;
    logic [CW-1:0] drop_next_s;
    aln_case_e     aln_s;
    logic [DW-1:0] raw_s;
    logic          avail_s;
    logic          off_next_s;
    logic [AW-1:0] pc_step_s;
    logic          unused_next_hi_s;

    fetch_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (bus.redirect_valid),
        .push      (rsp_keep_s),
        .push_data (bus.imem_rsp_data),
        .pop       (pop_s),
        .head      (head_s),
        .next      (next_s),
        .count     (count_s)
    );

    // Credit never goes negative: words are only requested into free slots
    assign credit_s    = DEPTH_C - count_s - out_cnt_r;
    assign req_valid_s = rst & (credit_s != {CW{1'b0}}) & ~bus.redirect_valid;
    assign req_fire_s  = req_valid_s & bus.imem_req_ready;
    assign rsp_keep_s  = bus.imem_rsp_valid & (drop_cnt_r == {CW{1'b0}}) & ~bus.redirect_valid;
    assign consume_s   = avail_s & bus.instr_ready & ~bus.redirect_valid;
    assign pop_s       = consume_s & (aln_s != ALN_C_LO);
    assign unused_next_hi_s = ^next_s[DW-1:16];

    // Outstanding/drop bookkeeping; a redirect turns everything in flight into drops
    always_comb begin
        out_next_s  = out_cnt_r;
        drop_next_s = drop_cnt_r;
        if (bus.redirect_valid) begin
            out_next_s  = out_cnt_r - {{(CW-1){1'b0}}, bus.imem_rsp_valid};
            drop_next_s = out_next_s;
        end else begin
            out_next_s = out_cnt_r + {{(CW-1){1'b0}}, req_fire_s}
                                   - {{(CW-1){1'b0}}, bus.imem_rsp_valid};
            if (bus.imem_rsp_valid && (drop_cnt_r != {CW{1'b0}})) begin
                drop_next_s = drop_cnt_r - {{(CW-1){1'b0}}, 1'b1};
            end else begin
                drop_next_s = drop_cnt_r;
            end
        end
    end

    // Aligner: classify the parcel at the current half-offset and build the instruction
    always_comb begin
        aln_s      = ALN_C_LO;
        raw_s      = {DW{1'b0}};
        avail_s    = 1'b0;
        off_next_s = off_r;
        pc_step_s  = AW'(ILEN_W);
        if (!off_r) begin
            aln_s = is_c(head_s[15:0]) ? ALN_C_LO : ALN_W_LO;
        end else begin
            aln_s = is_c(head_s[31:16]) ? ALN_C_HI : ALN_W_HI;
        end
        case (aln_s)
            ALN_C_LO: begin
                raw_s      = {16'h0000, head_s[15:0]};
                avail_s    = (count_s >= CW'(1));
                off_next_s = 1'b1;
                pc_step_s  = AW'(ILEN_C);
            end
            ALN_W_LO: begin
                raw_s      = head_s;
                avail_s    = (count_s >= CW'(1));
                off_next_s = 1'b0;
                pc_step_s  = AW'(ILEN_W);
            end
            ALN_C_HI: begin
                raw_s      = {16'h0000, head_s[31:16]};
                avail_s    = (count_s >= CW'(1));
                off_next_s = 1'b0;
                pc_step_s  = AW'(ILEN_C);
            end
            ALN_W_HI: begin
                raw_s      = {next_s[15:0], head_s[31:16]};
                avail_s    = (count_s >= CW'(2));
                off_next_s = 1'b1;
                pc_step_s  = AW'(ILEN_W);
            end
            default: begin
                raw_s      = {DW{1'b0}};
                avail_s    = 1'b0;
                off_next_s = off_r;
                pc_step_s  = AW'(ILEN_W);
            end
        endcase
    end

    // Fetch address, counters, half-offset and PC; redirect wins over everything
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_addr_r <= {RST_PC[AW-1:2], 2'b00};
            out_cnt_r    <= {CW{1'b0}};
            drop_cnt_r   <= {CW{1'b0}};
            off_r        <= RST_PC[1];
            cur_pc_r     <= RST_PC;
        end else begin
            out_cnt_r  <= out_next_s;
            drop_cnt_r <= drop_next_s;
            if (bus.redirect_valid) begin
                fetch_addr_r <= {bus.redirect_pc[AW-1:2], 2'b00};
                off_r        <= bus.redirect_pc[1];
                cur_pc_r     <= bus.redirect_pc;
            end else begin
                if (req_fire_s) fetch_addr_r <= fetch_addr_r + AW'(ILEN_W);
                if (consume_s) begin
                    cur_pc_r <= cur_pc_r + pc_step_s;
                    off_r    <= off_next_s;
                end
            end
        end
    end

    assign bus.imem_req_valid = req_valid_s;
    assign bus.imem_req_addr  = fetch_addr_r;
    assign bus.instr_valid    = avail_s;
    assign bus.instr          = avail_s ? raw_s : {DW{1'b0}};
    assign bus.instr_pc       = cur_pc_r;
    assign bus.instr_is_c     = avail_s & ((aln_s == ALN_C_LO) | (aln_s == ALN_C_HI));

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a latency-programmable memory model
// answers requests; expected request addresses and instructions are queued
// up front and compared as the DUT produces them.
module tb_fetch_unit;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        is_c;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } rsp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fetch_unit_if #(.AW(32), .DW(32)) bus ();

    fetch_unit #(.AW(32), .DW(32), .DEPTH(4), .RST_PC(32'h0000_0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t        exp_q[$];
    logic [31:0] exp_addr[$];
    rsp_t        rsp_q[$];
    logic [31:0] mem [0:255];

    int vectors     = 0;
    int miscompares = 0;
    int cyc, lat, nreq, ninstr;
    logic        tb_rdy, tb_irdy, tb_redir;
    logic [31:0] tb_redir_pc;

    // One clock cycle: drive inputs, act as memory, score outputs
    task automatic run_cycle();
        rsp_t        r;
        exp_t        e;
        logic [31:0] a;
        bus.redirect_valid = tb_redir;
        bus.redirect_pc    = tb_redir_pc;
        bus.imem_req_ready = tb_rdy;
        bus.instr_ready    = tb_irdy;
        if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
            r = rsp_q.pop_front();
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = mem[r.addr[9:2]];
        end else begin
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = 32'h0;
        end
        #1;
        if (bus.imem_req_valid && bus.imem_req_ready) begin
            nreq++;
            r.addr = bus.imem_req_addr;
            r.due  = cyc + lat;
            rsp_q.push_back(r);
            if (exp_addr.size() > 0) begin
                a = exp_addr.pop_front();
                vectors++;
                if (bus.imem_req_addr !== a) begin
                    miscompares++;
                    $display("FAIL req_addr: got %h expected %h (cycle %0d)", bus.imem_req_addr, a, cyc);
                end
            end
        end
        if (bus.instr_valid && bus.instr_ready && !bus.redirect_valid) begin
            ninstr++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                vectors++;
                if (bus.instr !== e.instr || bus.instr_pc !== e.pc || bus.instr_is_c !== e.is_c) begin
                    miscompares++;
                    $display("FAIL instr: got %h pc %h c %b expected %h pc %h c %b",
                             bus.instr, bus.instr_pc, bus.instr_is_c, e.instr, e.pc, e.is_c);
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic push_exp(input logic [31:0] i, input logic [31:0] pc, input logic c);
        exp_t e;
        e.instr = i;
        e.pc    = pc;
        e.is_c  = c;
        exp_q.push_back(e);
    endtask

    // Hold reset for two edges, clear the environment, release just after an edge
    task automatic reset_dut();
        rst = 1'b0;
        tb_rdy = 1'b1; tb_irdy = 1'b1; tb_redir = 1'b0; tb_redir_pc = 32'h0;
        lat = 1; nreq = 0; ninstr = 0;
        exp_q.delete(); exp_addr.delete(); rsp_q.delete();
        for (int i = 0; i < 256; i++) mem[i] = 32'h0000_0013;
        bus.redirect_valid = 1'b0; bus.redirect_pc = 32'h0;
        bus.imem_req_ready = 1'b1; bus.instr_ready = 1'b1;
        bus.imem_rsp_valid = 1'b0; bus.imem_rsp_data = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        cyc = 0;
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        #1;
        vectors += 5;
        if (bus.imem_req_valid !== 1'b0) begin miscompares++; $display("FAIL rst_req_valid: got %b expected 0", bus.imem_req_valid); end
        if (bus.instr_valid !== 1'b0)    begin miscompares++; $display("FAIL rst_instr_valid: got %b expected 0", bus.instr_valid); end
        if (bus.instr !== 32'h0)         begin miscompares++; $display("FAIL rst_instr: got %h expected 0", bus.instr); end
        if (bus.instr_pc !== 32'h0)      begin miscompares++; $display("FAIL rst_instr_pc: got %h expected 0", bus.instr_pc); end
        if (bus.instr_is_c !== 1'b0)     begin miscompares++; $display("FAIL rst_is_c: got %b expected 0", bus.instr_is_c); end
        reset_dut();
        #1;
        vectors++;
        if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h0) begin
            miscompares++;
            $display("FAIL first_req: got valid %b addr %h expected valid 1 addr 0", bus.imem_req_valid, bus.imem_req_addr);
        end
    endtask

    task automatic test_basic();
        reset_dut();
        for (int i = 0; i < 4; i++) begin
            exp_addr.push_back(32'(i * 4));
            push_exp(32'h0000_0013, 32'(i * 4), 1'b0);
        end
        repeat (6) run_cycle();
        vectors++;
        if (ninstr !== 4) begin miscompares++; $display("FAIL throughput: got %0d instrs expected 4 in 6 cycles", ninstr); end
        vectors++;
        if (exp_q.size() + exp_addr.size() != 0) begin miscompares++; $display("FAIL basic_drain: got %0d pending expected 0", exp_q.size() + exp_addr.size()); end
    endtask

    task automatic test_compressed();
        reset_dut();
        mem[0] = 32'h4501_4501;
        push_exp(32'h0000_4501, 32'h0, 1'b1);
        push_exp(32'h0000_4501, 32'h2, 1'b1);
        push_exp(32'h0000_0013, 32'h4, 1'b0);
        repeat (8) run_cycle();
        vectors++;
        if (exp_q.size() != 0) begin miscompares++; $display("FAIL compressed_drain: got %0d pending expected 0", exp_q.size()); end
    endtask

    task automatic test_cross();
        reset_dut();
        mem[0] = 32'h0013_4501;
        mem[1] = 32'h0000_0000;
        push_exp(32'h0000_4501, 32'h0, 1'b1);
        push_exp(32'h0000_0013, 32'h2, 1'b0);
        push_exp(32'h0000_0000, 32'h6, 1'b1);
        push_exp(32'h0000_0013, 32'h8, 1'b0);
        repeat (10) run_cycle();
        vectors++;
        if (exp_q.size() != 0) begin miscompares++; $display("FAIL cross_drain: got %0d pending expected 0", exp_q.size()); end
    endtask

    task automatic test_stall();
        reset_dut();
        for (int i = 0; i < 16; i++) mem[i] = 32'h0000_0013 | (32'(i) << 20);
        for (int i = 0; i < 4; i++) exp_addr.push_back(32'(i * 4));
        tb_irdy = 1'b0;
        repeat (10) run_cycle();
        vectors++;
        if (nreq !== 4) begin miscompares++; $display("FAIL stall_reqs: got %0d expected 4", nreq); end
        vectors++;
        if (bus.instr_valid !== 1'b1) begin miscompares++; $display("FAIL stall_hold: got %b expected 1", bus.instr_valid); end
        tb_irdy = 1'b1;
        for (int i = 0; i < 8; i++) push_exp(32'h0000_0013 | (32'(i) << 20), 32'(i * 4), 1'b0);
        repeat (14) run_cycle();
        vectors++;
        if (exp_q.size() != 0) begin miscompares++; $display("FAIL stall_drain: got %0d pending expected 0", exp_q.size()); end
    endtask

    task automatic test_redirect();
        reset_dut();
        lat = 4;
        for (int i = 0; i < 4; i++) mem[i] = 32'hDEAD_BEEF;
        mem[64] = 32'h4501_0013;
        mem[65] = 32'h0010_0093;
        exp_addr.push_back(32'h0); exp_addr.push_back(32'h4); exp_addr.push_back(32'h8);
        exp_addr.push_back(32'h100); exp_addr.push_back(32'h104);
        push_exp(32'h0000_4501, 32'h102, 1'b1);
        push_exp(32'h0010_0093, 32'h104, 1'b0);
        repeat (3) run_cycle();
        vectors++;
        if (nreq !== 3) begin miscompares++; $display("FAIL redir_outstanding: got %0d expected 3", nreq); end
        tb_redir = 1'b1;
        tb_redir_pc = 32'h102;
        run_cycle();
        tb_redir = 1'b0;
        lat = 1;
        vectors++;
        if (bus.instr_valid !== 1'b0) begin miscompares++; $display("FAIL redir_valid: got %b expected 0", bus.instr_valid); end
        repeat (12) run_cycle();
        vectors++;
        if (exp_q.size() + exp_addr.size() != 0) begin miscompares++; $display("FAIL redir_drain: got %0d pending expected 0", exp_q.size() + exp_addr.size()); end
    endtask

    task automatic test_reset_full();
        reset_dut();
        tb_irdy = 1'b0;
        repeat (8) run_cycle();
        vectors++;
        if (bus.instr_valid !== 1'b1) begin miscompares++; $display("FAIL full_before_rst: got %b expected 1", bus.instr_valid); end
        #2 rst = 1'b0;
        #1;
        vectors += 5;
        if (bus.imem_req_valid !== 1'b0) begin miscompares++; $display("FAIL full_rst_req_valid: got %b expected 0", bus.imem_req_valid); end
        if (bus.instr_valid !== 1'b0)    begin miscompares++; $display("FAIL full_rst_instr_valid: got %b expected 0", bus.instr_valid); end
        if (bus.instr !== 32'h0)         begin miscompares++; $display("FAIL full_rst_instr: got %h expected 0", bus.instr); end
        if (bus.instr_pc !== 32'h0)      begin miscompares++; $display("FAIL full_rst_pc: got %h expected 0", bus.instr_pc); end
        if (bus.instr_is_c !== 1'b0)     begin miscompares++; $display("FAIL full_rst_is_c: got %b expected 0", bus.instr_is_c); end
        reset_dut();
        mem[0] = 32'h0020_0113;
        exp_addr.push_back(32'h0);
        push_exp(32'h0020_0113, 32'h0, 1'b0);
        repeat (4) run_cycle();
        vectors++;
        if (exp_q.size() + exp_addr.size() != 0) begin miscompares++; $display("FAIL restart_drain: got %0d pending expected 0", exp_q.size() + exp_addr.size()); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_compressed();
        test_cross();
        test_stall();
        test_redirect();
        test_reset_full();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
